// File: rtl/cfg_write_arbiter.sv
// PWM configuration register bank with one write path shared by two valid/ready requesters.
// Port A is the SPI decoder and port B is the sequencer. Port B can be locked out of the bank.
module cfg_write_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       lock_b,
  output logic       wr_err,
  output logic       last_grant_b
);

  // Handshake: a requester holds valid/addr/data stable until its ready.
  // Ready is a one-cycle strobe in COMMIT, and the bank write happens at the end of that cycle.
  typedef enum logic {IDLE, COMMIT} state_t;

  state_t     state;
  state_t     state_next;
  logic       win_b;
  logic       win_b_next;
  logic [6:0] sel_addr;
  logic       drop_next;
  logic [6:0] hold_addr;
  logic [7:0] hold_data;
  logic       hold_err;

  always_comb begin
    state_next = state;
    win_b_next = win_b;
    case (state)
      IDLE: begin
        if (a_valid || b_valid) begin
          state_next = COMMIT;
          if (a_valid && b_valid)
            win_b_next = FIXED_PRIORITY ? 1'b0 : !last_grant_b;
          else
            win_b_next = b_valid;
        end
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The drop decision is taken at grant time.
  // lock_b cannot change while a write is pending.
  assign sel_addr  = win_b_next ? b_addr : a_addr;
  assign drop_next = (sel_addr > 7'h05) || (win_b_next && lock_b);

  // Reset during COMMIT withdraws the strobe, so the requester re-presents the write.
  assign a_ready = (state == COMMIT) && !win_b && !rst;
  assign b_ready = (state == COMMIT) && win_b && !rst;
  assign wr_err  = (state == COMMIT) && hold_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      win_b           <= 1'b0;
      hold_addr       <= 7'h00;
      hold_data       <= 8'h00;
      hold_err        <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      lock_b          <= 1'b0;
      last_grant_b    <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == COMMIT) begin
        win_b     <= win_b_next;
        hold_addr <= sel_addr;
        hold_data <= win_b_next ? b_data : a_data;
        hold_err  <= drop_next;
      end
      if (state == COMMIT) begin
        last_grant_b <= win_b;
        if (!hold_err) begin
          case (hold_addr)
            7'h00:   en_reg_out_7_0  <= hold_data;
            7'h01:   en_reg_out_15_8 <= hold_data;
            7'h02:   en_reg_pwm_7_0  <= hold_data;
            7'h03:   en_reg_pwm_15_8 <= hold_data;
            7'h04:   pwm_duty_cycle  <= hold_data;
            7'h05:   lock_b          <= hold_data[0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter.
// Instance 0 is round-robin and instance 1 is fixed-priority. Expected values are hand-computed.
module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid[2];
  logic [6:0] a_addr[2];
  logic [7:0] a_data[2];
  logic       a_ready[2];
  logic       b_valid[2];
  logic [6:0] b_addr[2];
  logic [7:0] b_data[2];
  logic       b_ready[2];
  logic [7:0] r0[2], r1[2], r2[2], r3[2], r4[2];
  logic       lock_b[2];
  logic       wr_err[2];
  logic       last_grant_b[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cfg_write_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[0]), .a_addr(a_addr[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_addr(b_addr[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
    .en_reg_out_7_0(r0[0]), .en_reg_out_15_8(r1[0]), .en_reg_pwm_7_0(r2[0]),
    .en_reg_pwm_15_8(r3[0]), .pwm_duty_cycle(r4[0]), .lock_b(lock_b[0]),
    .wr_err(wr_err[0]), .last_grant_b(last_grant_b[0])
  );

  cfg_write_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[1]), .a_addr(a_addr[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_addr(b_addr[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
    .en_reg_out_7_0(r0[1]), .en_reg_out_15_8(r1[1]), .en_reg_pwm_7_0(r2[1]),
    .en_reg_pwm_15_8(r3[1]), .pwm_duty_cycle(r4[1]), .lock_b(lock_b[1]),
    .wr_err(wr_err[1]), .last_grant_b(last_grant_b[1])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input int i, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                            input logic el, input string tag);
    check({tag, " out_7_0"}, r0[i], e0);
    check({tag, " out_15_8"}, r1[i], e1);
    check({tag, " pwm_7_0"}, r2[i], e2);
    check({tag, " pwm_15_8"}, r3[i], e3);
    check({tag, " duty"}, r4[i], e4);
    check({tag, " lock_b"}, {7'd0, lock_b[i]}, {7'd0, el});
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1'b0;
      b_valid[i] = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One write from one port.
  // Waits with a bounded budget for ready, checks the strobe shape, and returns the latency in cycles.
  task automatic single_write(input int i, input bit port, input logic [6:0] addr,
                              input logic [7:0] data, input logic exp_err, input string tag,
                              output int lat);
    logic got;
    if (!port) begin
      a_valid[i] = 1'b1; a_addr[i] = addr; a_data[i] = data;
    end else begin
      b_valid[i] = 1'b1; b_addr[i] = addr; b_data[i] = data;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      step();
      lat++;
      got = port ? b_ready[i] : a_ready[i];
    end
    check({tag, " ready"}, {7'd0, got}, 8'd1);
    check({tag, " wr_err"}, {7'd0, wr_err[i]}, {7'd0, exp_err});
    check({tag, " other ready"}, {7'd0, port ? a_ready[i] : b_ready[i]}, 8'd0);
    if (!port) a_valid[i] = 1'b0; else b_valid[i] = 1'b0;
    step();
    check({tag, " ready one cycle"}, {7'd0, port ? b_ready[i] : a_ready[i]}, 8'd0);
    check({tag, " wr_err one cycle"}, {7'd0, wr_err[i]}, 8'd0);
  endtask

  // Both ports hold requests continuously.
  // The expected grant order is A,B,A,B under round-robin and A,A,B,B under fixed priority.
  task automatic contend(input int i, input bit fp, input string tag);
    logic exp_q[$];
    int   ai, bi, last;
    do_reset();
    if (fp) exp_q = {1'b0, 1'b0, 1'b1, 1'b1};
    else    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    ai = 0; bi = 0; last = -1;
    a_valid[i] = 1'b1; a_addr[i] = 7'h00; a_data[i] = 8'h11;
    b_valid[i] = 1'b1; b_addr[i] = 7'h02; b_data[i] = 8'h33;
    for (int c = 0; c < 30 && (ai < 2 || bi < 2); c++) begin
      step();
      if (a_ready[i] || b_ready[i]) begin
        check({tag, " single ready"}, {7'd0, a_ready[i] & b_ready[i]}, 8'd0);
        if (exp_q.size() > 0)
          check({tag, " grant order"}, {7'd0, b_ready[i]}, {7'd0, exp_q.pop_front()});
        else
          check({tag, " extra grant"}, 8'd1, 8'd0);
        if (last >= 0) check({tag, " strobe spacing"}, 8'(c - last), 8'd2);
        last = c;
        if (fp && b_ready[i]) check({tag, " b while a_valid"}, {7'd0, a_valid[i]}, 8'd0);
      end
      if (a_ready[i]) begin
        ai++;
        if (ai == 1) begin a_addr[i] = 7'h01; a_data[i] = 8'h22; end
        else a_valid[i] = 1'b0;
      end
      if (b_ready[i]) begin
        bi++;
        if (bi == 1) begin b_addr[i] = 7'h03; b_data[i] = 8'h44; end
        else b_valid[i] = 1'b0;
      end
    end
    check({tag, " a grants"}, 8'(ai), 8'd2);
    check({tag, " b grants"}, 8'(bi), 8'd2);
    a_valid[i] = 1'b0;
    b_valid[i] = 1'b0;
    step();
    check_regs(i, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 1'b0, {tag, " final"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  got_b, got_a;
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1'b0; a_addr[i] = 7'h00; a_data[i] = 8'h00;
      b_valid[i] = 1'b0; b_addr[i] = 7'h00; b_data[i] = 8'h00;
    end
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      check_regs(i, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "reset");
      check("reset a_ready", {7'd0, a_ready[i]}, 8'd0);
      check("reset b_ready", {7'd0, b_ready[i]}, 8'd0);
      check("reset wr_err", {7'd0, wr_err[i]}, 8'd0);
      check("reset last_grant_b", {7'd0, last_grant_b[i]}, 8'd1);
    end
    rst = 1'b0;

    // Single write after reset, with ready on the first sampling edge.
    single_write(0, 1'b0, 7'h04, 8'h80, 1'b0, "single", lat);
    check("single latency", 8'(lat), 8'd1);
    check_regs(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 1'b0, "single");

    contend(0, 1'b0, "rr");
    contend(1, 1'b1, "fp");

    // Lock B out, confirm its writes drop, then unlock.
    do_reset();
    single_write(0, 1'b0, 7'h05, 8'h01, 1'b0, "lock set", lat);
    check("lock set lock_b", {7'd0, lock_b[0]}, 8'd1);
    single_write(0, 1'b1, 7'h04, 8'hFF, 1'b1, "locked duty", lat);
    single_write(0, 1'b1, 7'h05, 8'h00, 1'b1, "locked unlock", lat);
    check_regs(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, "locked");
    single_write(0, 1'b0, 7'h05, 8'h00, 1'b0, "lock clear", lat);
    single_write(0, 1'b1, 7'h04, 8'hFF, 1'b0, "unlocked duty", lat);
    check_regs(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "unlocked");

    // Out-of-range addresses are acked with wr_err, and the grant history still advances.
    do_reset();
    single_write(0, 1'b0, 7'h06, 8'hAA, 1'b1, "bad 06", lat);
    single_write(0, 1'b0, 7'h7F, 8'h55, 1'b1, "bad 7f", lat);
    check_regs(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "bad addr");
    check("bad addr last_grant_b", {7'd0, last_grant_b[0]}, 8'd0);
    a_valid[0] = 1'b1; a_addr[0] = 7'h00; a_data[0] = 8'h01;
    b_valid[0] = 1'b1; b_addr[0] = 7'h01; b_data[0] = 8'h02;
    got_a = 1'b0; got_b = 1'b0;
    for (int c = 0; c < 10 && !got_b && !got_a; c++) begin
      step();
      got_a = a_ready[0];
      got_b = b_ready[0];
    end
    check("tie after bad: b first", {7'd0, got_b}, 8'd1);
    check("tie after bad: a not first", {7'd0, got_a}, 8'd0);
    b_valid[0] = 1'b0;
    got_a = 1'b0;
    for (int c = 0; c < 10 && !got_a; c++) begin
      step();
      got_a = a_ready[0];
    end
    check("tie after bad: a later", {7'd0, got_a}, 8'd1);
    a_valid[0] = 1'b0;
    step();
    check_regs(0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0, "tie after bad");

    // Reset lands in the COMMIT cycle of a B write, so the write is lost and B retries.
    do_reset();
    b_valid[0] = 1'b1; b_addr[0] = 7'h02; b_data[0] = 8'h5A;
    step();
    rst = 1'b1;
    #1;
    check("midrst no b_ready", {7'd0, b_ready[0]}, 8'd0);
    step();
    rst = 1'b0;
    check_regs(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "midrst");
    check("midrst wr_err", {7'd0, wr_err[0]}, 8'd0);
    check("midrst last_grant_b", {7'd0, last_grant_b[0]}, 8'd1);
    single_write(0, 1'b1, 7'h02, 8'h5A, 1'b0, "midrst retry", lat);
    check_regs(0, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, "midrst retry");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
